// File: rtl/harmonic_mixer.sv
// Eight-harmonic mono mixer: snapshot, serial accumulate, gain, saturate, hold for codec.
// Optional peak-hold meter enabled with `define MIXER_PEAK_EN.
module harmonic_mixer #(
   parameter int MIX_SHIFT  = 3,
   parameter int PEAK_DECAY = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        samples_in_ready,
   input  logic [15:0] sample_in1,
   input  logic [15:0] sample_in2,
   input  logic [15:0] sample_in3,
   input  logic [15:0] sample_in4,
   input  logic [15:0] sample_in5,
   input  logic [15:0] sample_in6,
   input  logic [15:0] sample_in7,
   input  logic [15:0] sample_in8,
   input  logic        voice_on,
   input  logic [7:0]  master_volume,
   input  logic        out_accept,
   input  logic        clear_overrun,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun,
   output logic [14:0] peak_level
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SCALE = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [15:0] in_w [8];
   logic [15:0] snap_q [8];
   logic        voice_q;
   logic signed [18:0] acc_q;
   logic [2:0]  idx_q;
   logic [15:0] out_q;
   logic        ovr_q;

   logic capture_w;
   logic drop_w;
   logic fire_w;

   logic signed [18:0] mix_w;
   logic signed [27:0] prod_w;
   logic signed [27:0] res_w;
   logic [15:0]        sat_w;
   logic [15:0]        cur_w;

   always_comb begin
      in_w[0] = sample_in1;
      in_w[1] = sample_in2;
      in_w[2] = sample_in3;
      in_w[3] = sample_in4;
      in_w[4] = sample_in5;
      in_w[5] = sample_in6;
      in_w[6] = sample_in7;
      in_w[7] = sample_in8;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      capture_w = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (samples_in_ready) begin
               state_d   = ACCUM;
               capture_w = 1'b1;
            end
         end
         ACCUM: begin
            if (idx_q == 3'd7) state_d = SCALE;
         end
         SCALE: begin
            state_d = OUT;
         end
         OUT: begin
            if (out_accept) begin
               if (samples_in_ready) begin
                  state_d   = ACCUM;
                  capture_w = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q != IDLE);
      sample_valid = (state_q == OUT);
   end

   assign fire_w = (state_q == OUT) & out_accept;
   assign drop_w = samples_in_ready &
                   ((state_q == ACCUM) | (state_q == SCALE) |
                    ((state_q == OUT) & ~out_accept));

   // Gain stage: the 28-bit product of a 19-bit mix and 9-bit gain never wraps.
   always_comb begin
      mix_w  = voice_q ? (acc_q >>> MIX_SHIFT) : 19'sd0;
      prod_w = $signed({{9{mix_w[18]}}, mix_w} * {20'd0, master_volume});
      res_w  = prod_w >>> 8;
      if (res_w > 28'sd32767) begin
         sat_w = 16'h7fff;
      end else if (res_w < -28'sd32768) begin
         sat_w = 16'h8000;
      end else begin
         sat_w = res_w[15:0];
      end
   end

   assign cur_w = snap_q[idx_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) snap_q[i] <= '0;
         voice_q <= 1'b0;
         acc_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         if (capture_w) begin
            for (int i = 0; i < 8; i++) snap_q[i] <= in_w[i];
            voice_q <= voice_on;
            acc_q   <= '0;
            idx_q   <= '0;
         end else if (state_q == ACCUM) begin
            acc_q <= acc_q + $signed({{3{cur_w[15]}}, cur_w});
            idx_q <= idx_q + 3'd1;
         end
         if (state_q == SCALE) out_q <= sat_w;
         ovr_q <= drop_w | (ovr_q & ~clear_overrun);
      end
   end

   assign sample_out = out_q;
   assign overrun    = ovr_q;

`ifdef MIXER_PEAK_EN
   localparam int CW = $clog2(PEAK_DECAY + 1);

   logic [14:0]   peak_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   abs_w;
   logic [14:0]   mag_w;

   // |-32768| does not fit in 15 bits, so it reads as full scale.
   always_comb begin
      abs_w = out_q[15] ? (~out_q + 16'd1) : out_q;
      mag_w = abs_w[15] ? 15'h7fff : abs_w[14:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         peak_q <= '0;
         cnt_q  <= '0;
      end else if (fire_w) begin
         if (mag_w > peak_q) begin
            peak_q <= mag_w;
            cnt_q  <= '0;
         end else if (cnt_q == CW'(PEAK_DECAY - 1)) begin
            cnt_q  <= '0;
            peak_q <= (peak_q != 15'd0) ? peak_q - 15'd1 : 15'd0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign peak_level = peak_q;
`else
   // Meter disabled: output is a constant zero.
   assign peak_level = 15'(PEAK_DECAY) & 15'd0;
`endif

endmodule
